// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target -- SPI target (slave) peripheral on the RIB bus.
//
// An external SPI controller exchanges 8-bit MSB-first frames with the CPU.
// SCLK/SS/MOSI are oversampled in the clk_i domain through SYNC_STAGES flops.
// Edges are taken from the synchronized values, so clk_i must run at least
// 8x the SCLK rate. Received bytes land in a single-byte RX holding register.
// Bytes to send come from a single-byte TX holding register. When the TX
// holding register is empty at load time, FILL_BYTE is sent instead.
//
// Optional feature (macro SPI_TARGET_MODE_SEL_EN):
//   defined   : CTRL[2]=CPHA and CTRL[3]=CPOL select any of the four SPI modes.
//   undefined : fixed mode 0; CTRL[3:2] read 0 and writes to them are ignored.
//
// Register map (addr_i[7:0]):
//   0x00 CTRL   R/W  [0] en, [1] rx_ie, [2] cpha, [3] cpol (feature only)
//   0x04 STATUS      [0] rx_valid (W1C), [1] tx_empty (RO), [2] rx_ovr (W1C),
//                    [3] busy (RO)
//   0x08 TXDATA R/W  [7:0] tx_hold
//   0x0C RXDATA RO   [7:0] last received byte
//
// Ports:
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   we_i, addr_i, data_i  RIB write strobe, address, write data
//   data_o                RIB read data (combinational from addr_i)
//   spi_sclk_i            SPI clock from the controller
//   spi_ss_ni             SPI select, active-low
//   spi_mosi_i            controller-to-target data
//   spi_miso_o            target-to-controller data
//   spi_miso_oe_o         MISO pad output enable
//   irq_o                 level interrupt (rx_valid & rx_ie, registered)
// -----------------------------------------------------------------------------
module spi_target #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic        spi_sclk_i,
   input  logic        spi_ss_ni,
   input  logic        spi_mosi_i,
   output logic        spi_miso_o,
   output logic        spi_miso_oe_o,
   output logic        irq_o
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state, state_n;

   // Synchronizers and previous-value flops for edge detection
   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic                   sclk_prev, ss_prev;

   // Control / status registers
   logic       en, rx_ie;
   logic       rx_valid, rx_ovr, tx_empty;
   logic [7:0] tx_hold, rx_data;
   logic       irq_q;

   // Frame datapath
   logic [7:0] shift_tx, shift_rx;
   logic [2:0] bit_cnt;
   logic       miso_q, miso_oe_q;
   logic       first_lead;

   logic cpha, cpol;

   // Decoded events
   logic       sclk_s, ss_s, mosi_s;
   logic       sclk_cur, sclk_last;
   logic       lead_edge, trail_edge, sample_edge, shift_edge;
   logic       ss_fall, ss_rise;
   logic       wr_ctrl, wr_status, wr_tx, en_clear;
   logic       frame_start, frame_stop, do_sample, do_shift;
   logic [7:0] tx_byte;
   logic       busy;
   logic       unused_bits;

   assign unused_bits = ^{addr_i[31:8], data_i[31:8]};

   // ---------------------------------------------------------------- stage: input sync
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         ss_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_ni};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         ss_prev   <= ss_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // CPOL is folded into both the current and the previous sample, so
   // reprogramming CPOL never fabricates an SCLK edge.
   assign sclk_cur    = sclk_s ^ cpol;
   assign sclk_last   = sclk_prev ^ cpol;
   assign lead_edge   = sclk_cur & ~sclk_last;
   assign trail_edge  = ~sclk_cur & sclk_last;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge : trail_edge;
   assign ss_fall     = ss_prev & ~ss_s;
   assign ss_rise     = ~ss_prev & ss_s;

   assign wr_ctrl   = we_i && (addr_i[7:0] == 8'h00);
   assign wr_status = we_i && (addr_i[7:0] == 8'h04);
   assign wr_tx     = we_i && (addr_i[7:0] == 8'h08);
   assign en_clear  = wr_ctrl && !data_i[0];

   assign tx_byte = tx_empty ? FILL_BYTE : tx_hold;
   assign busy    = ~ss_s & en;

   // ---------------------------------------------------------------- stage: frame FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n     = state;
      frame_start = 1'b0;
      frame_stop  = 1'b0;
      do_sample   = 1'b0;
      do_shift    = 1'b0;
      case (state)
         IDLE: begin
            if (en && ss_fall && !en_clear) begin
               state_n     = ACTIVE;
               frame_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise || !en || en_clear) begin
               state_n    = IDLE;
               frame_stop = 1'b1;
            end else begin
               do_sample = sample_edge;
               do_shift  = shift_edge;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- stage: registers and shifters
   // Statement order encodes collision priority: CPU W1C clears come before
   // byte completion (completion wins); TX loads come before the TXDATA write
   // (the write wins, leaving the new byte pending).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         en         <= 1'b0;
         rx_ie      <= 1'b0;
         rx_valid   <= 1'b0;
         rx_ovr     <= 1'b0;
         tx_empty   <= 1'b1;
         tx_hold    <= 8'h00;
         rx_data    <= 8'h00;
         irq_q      <= 1'b0;
         shift_tx   <= 8'h00;
         shift_rx   <= 8'h00;
         bit_cnt    <= 3'd0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         first_lead <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en    <= data_i[0];
            rx_ie <= data_i[1];
         end
         if (wr_status) begin
            if (data_i[0]) rx_valid <= 1'b0;
            if (data_i[2]) rx_ovr   <= 1'b0;
         end

         if (frame_start) begin
            shift_tx   <= tx_byte;
            tx_empty   <= 1'b1;
            bit_cnt    <= 3'd0;
            miso_oe_q  <= 1'b1;
            // With CPHA=1 the MSB appears only on the first leading edge.
            miso_q     <= cpha ? 1'b0 : tx_byte[7];
            first_lead <= cpha;
         end

         if (do_shift) begin
            if (first_lead) begin
               miso_q     <= shift_tx[7];
               first_lead <= 1'b0;
            end else if (bit_cnt == 3'd0) begin
               shift_tx <= tx_byte;
               tx_empty <= 1'b1;
               miso_q   <= tx_byte[7];
            end else begin
               shift_tx <= {shift_tx[6:0], 1'b0};
               miso_q   <= shift_tx[6];
            end
         end

         if (do_sample) begin
            shift_rx <= {shift_rx[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_data  <= {shift_rx[6:0], mosi_s};
               rx_valid <= 1'b1;
               if (rx_valid) rx_ovr <= 1'b1;
            end
         end

         if (frame_stop) begin
            bit_cnt    <= 3'd0;
            miso_oe_q  <= 1'b0;
            miso_q     <= 1'b0;
            first_lead <= 1'b0;
         end

         if (wr_tx) begin
            tx_hold  <= data_i[7:0];
            tx_empty <= 1'b0;
         end

         irq_q <= rx_valid & rx_ie;
      end
   end

`ifdef SPI_TARGET_MODE_SEL_EN
   logic cpha_q, cpol_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cpha_q <= 1'b0;
         cpol_q <= 1'b0;
      end else if (wr_ctrl) begin
         cpha_q <= data_i[2];
         cpol_q <= data_i[3];
      end
   end

   assign cpha = cpha_q;
   assign cpol = cpol_q;
`else
   assign cpha = 1'b0;
   assign cpol = 1'b0;
`endif

   // ---------------------------------------------------------------- stage: bus read and outputs
   always_comb begin
      data_o = 32'h0;
      case (addr_i[7:0])
         8'h00:   data_o = {28'h0, cpol, cpha, rx_ie, en};
         8'h04:   data_o = {28'h0, busy, rx_ovr, tx_empty, rx_valid};
         8'h08:   data_o = {24'h0, tx_hold};
         8'h0C:   data_o = {24'h0, rx_data};
         default: data_o = 32'h0;
      endcase
   end

   assign spi_miso_o    = miso_q;
   assign spi_miso_oe_o = miso_oe_q;
   assign irq_o         = irq_q;

endmodule

// File: tb/tb_spi_target.sv
// -----------------------------------------------------------------------------
// tb_spi_target -- self-checking bench for spi_target.
// A register-access vector table is applied first. Hand-written SPI controller
// sequences then cover frames, the empty-TX fill byte, abort, the W1C/completion
// collision, the disabled state and the mode-select feature.
// -----------------------------------------------------------------------------
module tb_spi_target;

   localparam int H = 8;   // clk_i cycles per SCLK half period

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        spi_sclk_i;
   logic        spi_ss_ni;
   logic        spi_mosi_i;
   logic        spi_miso_o;
   logic        spi_miso_oe_o;
   logic        irq_o;

   int checks   = 0;
   int failures = 0;

   spi_target #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .we_i          (we_i),
      .addr_i        (addr_i),
      .data_i        (data_i),
      .data_o        (data_o),
      .spi_sclk_i    (spi_sclk_i),
      .spi_ss_ni     (spi_ss_ni),
      .spi_mosi_i    (spi_mosi_i),
      .spi_miso_o    (spi_miso_o),
      .spi_miso_oe_o (spi_miso_oe_o),
      .irq_o         (irq_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic        we;
      logic [7:0]  waddr;
      logic [31:0] wdata;
      logic [7:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
      addr_i = {24'h0, a};
      data_i = d;
      we_i   = 1'b1;
      tick(1);
      we_i   = 1'b0;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
      addr_i = {24'h0, a};
      #1;
      d = data_o;
   endtask

   // Controller side: shifts the first n bits (MSB first) of tx, captures MISO.
   // m3=0: mode 0 (idle low, sample on rise). m3=1: mode 3 (idle high).
   task automatic spi_bits(input logic [7:0] tx, input int n, input bit m3,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         int b;
         b = 7 - i;
         if (!m3) begin
            spi_mosi_i = tx[b];
            tick(H);
            rx[b] = spi_miso_o;
            spi_sclk_i = 1'b1;
            tick(H);
            spi_sclk_i = 1'b0;
         end else begin
            spi_sclk_i = 1'b0;
            spi_mosi_i = tx[b];
            tick(H);
            rx[b] = spi_miso_o;
            spi_sclk_i = 1'b1;
            tick(H);
         end
      end
   endtask

   task automatic ss_begin();
      spi_ss_ni = 1'b0;
      tick(H);
   endtask

   task automatic ss_end();
      tick(H);
      spi_ss_ni = 1'b1;
      tick(H);
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  rx, rx2;

      rst_i      = 1'b1;
      we_i       = 1'b0;
      addr_i     = 32'h0;
      data_i     = 32'h0;
      spi_sclk_i = 1'b0;
      spi_ss_ni  = 1'b1;
      spi_mosi_i = 1'b0;
      tick(3);
      rst_i = 1'b0;
      tick(1);

      check("reset_oe",   {31'h0, spi_miso_oe_o}, 32'h0);
      check("reset_irq",  {31'h0, irq_o},         32'h0);
      check("reset_miso", {31'h0, spi_miso_o},    32'h0);

      // Register access table; we=0 entries are pure reads.
      vecs[0]  = '{"rst_status",   1'b0, 8'h00, 32'h0,        8'h04, 32'h2};
      vecs[1]  = '{"rst_ctrl",     1'b0, 8'h00, 32'h0,        8'h00, 32'h0};
      vecs[2]  = '{"rst_rxdata",   1'b0, 8'h00, 32'h0,        8'h0C, 32'h0};
      vecs[3]  = '{"rst_txdata",   1'b0, 8'h00, 32'h0,        8'h08, 32'h0};
      vecs[4]  = '{"rd_unmapped",  1'b0, 8'h00, 32'h0,        8'h10, 32'h0};
      vecs[5]  = '{"wr_ctrl_ie",   1'b1, 8'h00, 32'h2,        8'h00, 32'h2};
      vecs[6]  = '{"wr_txdata",    1'b1, 8'h08, 32'h1A5,      8'h08, 32'hA5};
      vecs[7]  = '{"tx_empty_clr", 1'b0, 8'h00, 32'h0,        8'h04, 32'h0};
      vecs[8]  = '{"wr_unmapped",  1'b1, 8'h10, 32'hFFFF,     8'h10, 32'h0};
      vecs[9]  = '{"wr_rxdata_ro", 1'b1, 8'h0C, 32'h55,       8'h0C, 32'h0};
      vecs[10] = '{"wr_status_ro", 1'b1, 8'h04, 32'hF,        8'h04, 32'h0};

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].we) reg_write(vecs[i].waddr, vecs[i].wdata);
         reg_read(vecs[i].raddr, rd);
         check(vecs[i].name, rd, vecs[i].exp);
         tick(1);
      end

      // Basic byte exchange in mode 0
      reg_write(8'h00, 32'h3);
      reg_write(8'h08, 32'hA5);
      ss_begin();
      check("basic_oe_active", {31'h0, spi_miso_oe_o}, 32'h1);
      spi_bits(8'h3C, 8, 1'b0, rx);
      check("basic_miso_byte", {24'h0, rx}, 32'hA5);
      tick(4);
      reg_read(8'h04, rd);
      check("basic_status_lo", rd & 32'h7, 32'h3);
      check("basic_busy", (rd >> 3) & 32'h1, 32'h1);
      check("basic_irq_set", {31'h0, irq_o}, 32'h1);
      ss_end();
      reg_read(8'h04, rd);
      check("basic_status_idle", rd, 32'h3);
      reg_read(8'h0C, rd);
      check("basic_rxdata", rd, 32'h3C);
      check("basic_oe_idle", {31'h0, spi_miso_oe_o}, 32'h0);
      tick(1);
      reg_write(8'h04, 32'h1);
      tick(2);
      check("basic_irq_clr", {31'h0, irq_o}, 32'h0);
      reg_read(8'h04, rd);
      check("basic_status_clr", rd, 32'h2);
      tick(1);

      // Empty TX: two bytes of fill, second completion flags overrun
      ss_begin();
      spi_bits(8'h11, 8, 1'b0, rx);
      spi_bits(8'h22, 8, 1'b0, rx2);
      ss_end();
      check("fill_byte0", {24'h0, rx},  32'hFF);
      check("fill_byte1", {24'h0, rx2}, 32'hFF);
      reg_read(8'h0C, rd);
      check("fill_rxdata", rd, 32'h22);
      reg_read(8'h04, rd);
      check("fill_status_ovr", rd, 32'h7);
      tick(1);
      reg_write(8'h04, 32'h5);
      reg_read(8'h04, rd);
      check("fill_status_clr", rd, 32'h2);
      tick(1);

      // Abort after 5 bits, then a full frame must realign
      ss_begin();
      spi_bits(8'hF0, 5, 1'b0, rx);
      ss_end();
      reg_read(8'h04, rd);
      check("abort_status", rd, 32'h2);
      reg_read(8'h0C, rd);
      check("abort_rxdata", rd, 32'h22);
      check("abort_oe", {31'h0, spi_miso_oe_o}, 32'h0);
      tick(1);
      reg_write(8'h08, 32'h96);
      ss_begin();
      spi_bits(8'h81, 8, 1'b0, rx);
      ss_end();
      check("after_abort_miso", {24'h0, rx}, 32'h96);
      reg_read(8'h0C, rd);
      check("after_abort_rxdata", rd, 32'h81);
      tick(1);
      reg_write(8'h04, 32'h1);

      // Collision: W1C of rx_valid lands on the cycle of the 8th sample
      ss_begin();
      spi_bits(8'h5C, 8, 1'b0, rx);
      spi_bits(8'h3B, 7, 1'b0, rx);
      spi_mosi_i = 1'b1;
      tick(H);
      spi_sclk_i = 1'b1;
      tick(2);
      addr_i = 32'h4;
      data_i = 32'h1;
      we_i   = 1'b1;
      tick(1);
      we_i   = 1'b0;
      tick(H - 3);
      spi_sclk_i = 1'b0;
      ss_end();
      reg_read(8'h04, rd);
      check("collide_rx_valid", rd & 32'h1, 32'h1);
      check("collide_rx_ovr", (rd >> 2) & 32'h1, 32'h1);
      reg_read(8'h0C, rd);
      check("collide_rxdata", rd, 32'h3B);
      tick(1);
      reg_write(8'h04, 32'h5);

      // Disabled: SS and SCLK ignored
      reg_write(8'h00, 32'h2);
      ss_begin();
      check("dis_oe", {31'h0, spi_miso_oe_o}, 32'h0);
      spi_bits(8'h77, 8, 1'b0, rx);
      ss_end();
      reg_read(8'h04, rd);
      check("dis_status", rd, 32'h2);
      reg_read(8'h0C, rd);
      check("dis_rxdata", rd, 32'h3B);
      tick(1);

`ifdef SPI_TARGET_MODE_SEL_EN
      reg_write(8'h00, 32'hD);
      reg_read(8'h00, rd);
      check("mode3_ctrl", rd, 32'hD);
      tick(1);
      reg_write(8'h08, 32'h5A);
      spi_sclk_i = 1'b1;
      tick(H);
      ss_begin();
      spi_bits(8'hC3, 8, 1'b1, rx);
      ss_end();
      check("mode3_miso_byte", {24'h0, rx}, 32'h5A);
      reg_read(8'h0C, rd);
      check("mode3_rxdata", rd, 32'hC3);
      spi_sclk_i = 1'b0;
`else
      reg_write(8'h00, 32'hD);
      reg_read(8'h00, rd);
      check("mode_fixed_ctrl", rd, 32'h1);
`endif
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
